// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: three requesters in, one register-file write out.
// The arbiter takes the slave side; the requester/RF side takes master.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [2:0]          req_valid;
  logic [2:0]          req_ready;
  logic [3*ADDR_W-1:0] req_rd;
  logic [3*DATA_W-1:0] req_data;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic [1:0]          wb_sel;

  modport master (
    output req_valid,
    output req_rd,
    output req_data,
    input  req_ready,
    input  rf_we,
    input  rf_waddr,
    input  rf_wdata,
    input  wb_sel
  );

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_data,
    output req_ready,
    output rf_we,
    output rf_waddr,
    output rf_wdata,
    output wb_sel
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Requesters: 0 = PC link, 1 = ALU result, 2 = load data.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_port_arbiter_if.slave bus
);

  logic [1:0]        r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_sel;

  logic [2:0]        w_valid;
  logic [2:0]        w_grant;
  logic              w_xfer;
  logic [1:0]        w_idx;
  logic [ADDR_W-1:0] w_rd;
  logic [DATA_W-1:0] w_data;

  assign w_valid = bus.req_valid;

  // Search begins one past the last winner and wraps 2 -> 0.
  always_comb begin
    w_grant = 3'b000;
    unique case (r_last)
      2'd0: begin
        if (w_valid[1])      w_grant = 3'b010;
        else if (w_valid[2]) w_grant = 3'b100;
        else if (w_valid[0]) w_grant = 3'b001;
      end
      2'd1: begin
        if (w_valid[2])      w_grant = 3'b100;
        else if (w_valid[0]) w_grant = 3'b001;
        else if (w_valid[1]) w_grant = 3'b010;
      end
      default: begin
        if (w_valid[0])      w_grant = 3'b001;
        else if (w_valid[1]) w_grant = 3'b010;
        else if (w_valid[2]) w_grant = 3'b100;
      end
    endcase
    if (!rst_n) w_grant = 3'b000;
  end

  assign w_xfer = |w_grant;

  always_comb begin
    w_idx  = 2'd0;
    w_rd   = bus.req_rd[0 +: ADDR_W];
    w_data = bus.req_data[0 +: DATA_W];
    unique case (1'b1)
      w_grant[1]: begin
        w_idx  = 2'd1;
        w_rd   = bus.req_rd[ADDR_W +: ADDR_W];
        w_data = bus.req_data[DATA_W +: DATA_W];
      end
      w_grant[2]: begin
        w_idx  = 2'd2;
        w_rd   = bus.req_rd[2*ADDR_W +: ADDR_W];
        w_data = bus.req_data[2*DATA_W +: DATA_W];
      end
      default: begin
        w_idx  = 2'd0;
        w_rd   = bus.req_rd[0 +: ADDR_W];
        w_data = bus.req_data[0 +: DATA_W];
      end
    endcase
  end

  // An rd of zero still wins and advances the pointer, it just never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= 2'd2;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_sel   <= 2'b01;
    end else if (w_xfer) begin
      r_last  <= w_idx;
      r_we    <= |w_rd;
      r_waddr <= w_rd;
      r_wdata <= w_data;
      r_sel   <= w_idx;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rf_we     = r_we;
  assign bus.rf_waddr  = r_waddr;
  assign bus.rf_wdata  = r_wdata;
  assign bus.wb_sel    = r_sel;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed literal cases plus random traffic
// against a queue-free round-robin model.
module tb_wb_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [2:0]    v;
  logic [AW-1:0] rd  [3];
  logic [DW-1:0] dat [3];

  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [1:0]    m_sel;
  logic [2:0]    m_grant;
  int            waits [3];
  logic [2:0]    last_ready;

  logic [2:0] er028 [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [1:0] es028 [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
  logic [4:0] ea028 [4] = '{5'd1, 5'd2, 5'd3, 5'd1};

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.req_valid = v;
    for (int i = 0; i < 3; i++) begin
      bus.req_rd[i*AW +: AW]   = rd[i];
      bus.req_data[i*DW +: DW] = dat[i];
    end
  endtask

  function automatic logic [2:0] rr_pick(logic [2:0] vv, int p);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (p + k) % 3;
      if (vv[idx]) return 3'(1 << idx);
    end
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_ptr   = 2;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_sel   = 2'b01;
    m_grant = 3'b000;
    for (int i = 0; i < 3; i++) waits[i] = 0;
  endtask

  // One clock: compare at negedge, advance the model, return at posedge+1.
  task automatic step();
    int gi;
    drive();
    @(negedge clk);
    m_grant    = rr_pick(v, m_ptr);
    last_ready = bus.req_ready;
    chk("ready",    64'(bus.req_ready), 64'(m_grant));
    chk("rf_we",    64'(bus.rf_we),     64'(m_we));
    chk("rf_waddr", 64'(bus.rf_waddr),  64'(m_waddr));
    chk("rf_wdata", 64'(bus.rf_wdata),  64'(m_wdata));
    chk("wb_sel",   64'(bus.wb_sel),    64'(m_sel));
    if (m_grant != 3'b000) begin
      gi = m_grant[0] ? 0 : (m_grant[1] ? 1 : 2);
      for (int i = 0; i < 3; i++) begin
        if (i != gi && v[i]) begin
          waits[i]++;
          chk("starve", 64'(waits[i] <= 2), 64'd1);
        end
      end
      waits[gi] = 0;
      m_we    = (rd[gi] != '0);
      m_waddr = rd[gi];
      m_wdata = dat[gi];
      m_sel   = 2'(gi);
      m_ptr   = gi;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(int i);
    v[i]   = 1'b1;
    rd[i]  = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
    dat[i] = $urandom;
  endtask

  task automatic mid_reset();
    v = 3'b111;
    drive();
    rst_n = 1'b0;
    #2;
    chk("arst_ready", 64'(bus.req_ready), 64'd0);
    chk("arst_we",    64'(bus.rf_we),     64'd0);
    chk("arst_waddr", 64'(bus.rf_waddr),  64'd0);
    chk("arst_wdata", 64'(bus.rf_wdata),  64'd0);
    chk("arst_sel",   64'(bus.wb_sel),    64'd1);
    model_reset();
    @(posedge clk);
    #1;
    v = 3'b101;
    drive();
    rst_n = 1'b1;
    step();
    chk("post_rst_pc_first", 64'(last_ready), 64'b001);
  endtask

  initial begin
    rst_n = 1'b0;
    v = 3'b111;
    rd[0] = 5'd1; rd[1] = 5'd2; rd[2] = 5'd3;
    dat[0] = 32'h1111_0000; dat[1] = 32'h2222_0000; dat[2] = 32'h3333_0000;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_we",    64'(bus.rf_we),     64'd0);
    chk("rst_waddr", 64'(bus.rf_waddr),  64'd0);
    chk("rst_wdata", 64'(bus.rf_wdata),  64'd0);
    chk("rst_sel",   64'(bus.wb_sel),    64'd1);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr3_ready", 64'(last_ready),   64'(er028[k]));
      chk("rr3_we",    64'(bus.rf_we),    64'd1);
      chk("rr3_sel",   64'(bus.wb_sel),   64'(es028[k]));
      chk("rr3_waddr", 64'(bus.rf_waddr), 64'(ea028[k]));
    end

    v = 3'b010; rd[1] = 5'd5; dat[1] = 32'hDEAD_BEEF;
    step();
    chk("alu_ready", 64'(last_ready),   64'b010);
    chk("alu_we",    64'(bus.rf_we),    64'd1);
    chk("alu_waddr", 64'(bus.rf_waddr), 64'd5);
    chk("alu_wdata", 64'(bus.rf_wdata), 64'hDEAD_BEEF);
    chk("alu_sel",   64'(bus.wb_sel),   64'b01);

    v = 3'b100; rd[2] = 5'd0; dat[2] = 32'h1234_5678;
    step();
    chk("ld0_ready", 64'(last_ready),   64'b100);
    chk("ld0_we",    64'(bus.rf_we),    64'd0);
    chk("ld0_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("ld0_sel",   64'(bus.wb_sel),   64'b10);
    v = 3'b011;
    step();
    chk("ld0_next_ready", 64'(last_ready), 64'b001);

    v = 3'b010; rd[1] = 5'd7; dat[1] = 32'hA5A5_5A5A;
    step();
    v = 3'b000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_we",    64'(bus.rf_we),    64'd0);
      chk("idle_waddr", 64'(bus.rf_waddr), 64'd7);
      chk("idle_wdata", 64'(bus.rf_wdata), 64'hA5A5_5A5A);
      chk("idle_sel",   64'(bus.wb_sel),   64'b01);
    end

    v = 3'b010;
    repeat (2) step();
    v = 3'b110; rd[2] = 5'd9; dat[2] = 32'h0BAD_F00D;
    step();
    chk("ld_join_ready", 64'(last_ready), 64'b100);
    v = 3'b010;
    step();
    chk("alu_after_ld", 64'(last_ready), 64'b010);

    v = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (v[i] && m_grant[i]) begin
          if ($urandom_range(0, 9) < 6) new_req(i);
          else v[i] = 1'b0;
        end else if (v[i]) begin
          if ($urandom_range(0, 19) == 0) v[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          new_req(i);
        end
        if (!v[i]) waits[i] = 0;
      end
      step();
      if (c == 1500) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of writeback data.
REQ-002 Parameter ADDR_W, default 5, width of register-file destination index.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 Port req_valid  input  3  per-requester write request: bit0 = PC link (PC+4), bit1 = ALU result, bit2 = load data.
REQ-006 Port req_ready  output  3  per-requester grant, one-hot or zero.
REQ-007 Port req_rd  input  3*ADDR_W  destination indices, requester i in slice [i*ADDR_W +: ADDR_W].
REQ-008 Port req_data  input  3*DATA_W  write data, requester i in slice [i*DATA_W +: DATA_W].
REQ-009 Port rf_we  output  1  register-file write enable, registered.
REQ-010 Port rf_waddr  output  ADDR_W  register-file write index, registered.
REQ-011 Port rf_wdata  output  DATA_W  register-file write data, registered.
REQ-012 Port wb_sel  output  2  source of the last accepted write: 00 PC link, 01 ALU, 10 load; 11 never driven.

Function
REQ-013 The block SHALL arbitrate the single register-file write port among the three requesters, granting at most one per cycle.
REQ-014 req_ready SHALL be combinational from req_valid and the last-grant pointer; a transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-015 Arbitration SHALL be round-robin: search starts at index (last_grant+1) mod 3, wraps 2->0, and grants the first valid requester found.
REQ-016 The last-grant pointer SHALL update to i only on a transfer by requester i; with no transfer it holds.
REQ-017 With no valid requester, req_ready SHALL be 3'b000.
REQ-018 Latency SHALL be one cycle: on a transfer by requester i, the next cycle shows rf_waddr = req_rd[i], rf_wdata = req_data[i], wb_sel = i.
REQ-019 On that next cycle rf_we SHALL be 1 if req_rd[i] != 0, else 0; an rd = 0 transfer still completes its handshake and advances the pointer.
REQ-020 In a cycle following no transfer, rf_we SHALL be 0 and rf_waddr, rf_wdata, wb_sel SHALL hold their previous values.
REQ-021 rf_we SHALL be high for exactly one cycle per accepted non-zero-rd transfer; back-to-back transfers SHALL give back-to-back write cycles with no bubble.
REQ-022 Requesters SHALL hold req_valid, req_rd, req_data stable until granted; the block SHALL NOT latch request contents before the transfer edge.
REQ-023 A requester deasserting valid before grant SHALL lose no state in the block; its next request is arbitrated normally.
REQ-024 No requester SHALL wait more than two transfers by others while continuously valid.

Reset
REQ-025 While rst_n is low: rf_we = 0, rf_waddr = 0, rf_wdata = 0, wb_sel = 2'b01, last-grant pointer = 2, req_ready = 3'b000.
REQ-026 Reset assertion SHALL take effect immediately regardless of clk; a transfer in flight is discarded and no write is issued for it.
REQ-027 After rst_n deasserts, the first arbitration SHALL begin at index 0.

Verification
REQ-028 Reset release, all three req_valid held with rd = 1,2,3 -> req_ready cycles 001,010,100,001; rf_we high every cycle from the second, wb_sel 00,01,10,00, rf_waddr 1,2,3,1.
REQ-029 Only ALU valid, rd = 5, data = 0xDEADBEEF -> req_ready = 010 that cycle; next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF, wb_sel = 01.
REQ-030 Only load valid, rd = 0, data = 0x12345678 -> req_ready = 100; next cycle rf_we = 0, rf_waddr = 0, wb_sel = 10; next grant search starts at index 0.
REQ-031 After a write to rd = 7, all req_valid low for 3 cycles -> rf_we = 0, rf_waddr stays 7, rf_wdata and wb_sel unchanged.
REQ-032 rst_n pulled low mid-cycle during continuous traffic -> outputs reach reset values before the next clk edge; after release with PC and load valid, PC is granted first.
REQ-033 ALU held valid every cycle, load asserted once and held -> load granted no later than the second cycle after it asserts; ALU granted on the following cycle.
